// File: rtl/reg_bank_spiller_pkg.sv
// reg_spill_pkg: shared state encoding, command codes and widths for the
// register-bank spill/fill engine.
package reg_spill_pkg;

   localparam int REG_W     = 16;
   localparam int BANK_W    = 6;
   localparam int RF_ADDR_W = 5;

   localparam logic CMD_SPILL = 1'b0;
   localparam logic CMD_FILL  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SP_RD  = 3'd1,
      SP_CAP = 3'd2,
      SP_MEM = 3'd3,
      FL_REQ = 3'd4,
      FL_RSP = 3'd5,
      FL_WR  = 3'd6,
      DONE   = 3'd7
   } spill_state_t;

   // Memory word address of a register: wraps modulo 2^REG_W.
   function automatic logic [REG_W-1:0] word_addr(input logic [REG_W-1:0] base,
                                                   input logic [REG_W-1:0] offset);
      return base + offset;
   endfunction

endpackage

// File: rtl/reg_bank_spiller_checksum.sv
// reg_spill_checksum: 16-bit XOR accumulator over transferred words.
// Cleared when a command is accepted, folded in once per transferred word.
module reg_spill_checksum
   import reg_spill_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             accumulate,
   input  logic [REG_W-1:0] data,
   output logic [REG_W-1:0] sum
);

   // Accumulate XOR of each transferred word; clear takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= '0;
      end else if (clear) begin
         sum <= '0;
      end else if (accumulate) begin
         sum <= sum ^ data;
      end
   end

endmodule

// File: rtl/reg_bank_spiller.sv
// reg_bank_spiller: spills one register bank to data memory or fills it back,
// driving the register file's port A and the load/store memory port.
// Optional feature: define REG_SPILL_CHECKSUM_EN to build the XOR checksum on
// checksum_o; otherwise checksum_o is tied to zero.
//
// Handshakes: a command transfers when cmdValid_i && cmdReady_o on a rising
// edge; a memory request transfers when memReqValid_o && memReqReady_i, and
// the request fields stay stable until then. memRspValid_i is a single-cycle
// strobe that is only observed while waiting for a load response.
module reg_bank_spiller
   import reg_spill_pkg::*;
#(
   parameter int NUM_REGISTERS_PER_BANK = 16,
   parameter int NUM_REG_BANKS          = 2
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 cmdValid_i,
   output logic                 cmdReady_o,
   input  logic                 cmdFill_i,
   input  logic [BANK_W-1:0]    cmdBank_i,
   input  logic [REG_W-1:0]     cmdBase_i,
   output logic [BANK_W-1:0]    bankSelect_o,
   output logic                 rfReadEnable_o,
   output logic [RF_ADDR_W-1:0] rfReadAddr_o,
   input  logic [REG_W-1:0]     rfReadData_i,
   output logic                 rfWriteEnable_o,
   output logic [RF_ADDR_W-1:0] rfWriteAddr_o,
   output logic [REG_W-1:0]     rfWriteData_o,
   output logic                 memReqValid_o,
   input  logic                 memReqReady_i,
   output logic                 memReqWrite_o,
   output logic [REG_W-1:0]     memReqAddr_o,
   output logic [REG_W-1:0]     memReqData_o,
   input  logic                 memRspValid_i,
   input  logic [REG_W-1:0]     memRspData_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [REG_W-1:0]     checksum_o,
   output logic [2:0]           state_o
);

   localparam int IDX_W = (NUM_REGISTERS_PER_BANK > 1) ? $clog2(NUM_REGISTERS_PER_BANK) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_REGISTERS_PER_BANK - 1);
   localparam logic [BANK_W:0]   BANK_LIMIT = (BANK_W + 1)'(NUM_REG_BANKS);

   spill_state_t      state;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_next;
   logic [REG_W-1:0]  base_q;
   logic [REG_W-1:0]  data_q;
   logic              cmd_accept;
   logic              bank_bad;

   assign cmd_accept    = cmdValid_i && cmdReady_o && (state == IDLE);
   assign bank_bad      = {1'b0, cmdBank_i} >= BANK_LIMIT;
   assign idx_next      = idx + IDX_W'(1);
   // One data register serves both directions: RF read data on a spill,
   // load data on a fill.
   assign memReqData_o  = data_q;
   assign rfWriteData_o = data_q;
   assign state_o       = state;

   // Transfer FSM with registered outputs; each transition sets the outputs
   // the destination state presents.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state           <= IDLE;
         idx             <= '0;
         base_q          <= '0;
         data_q          <= '0;
         bankSelect_o    <= '0;
         cmdReady_o      <= 1'b0;
         rfReadEnable_o  <= 1'b0;
         rfReadAddr_o    <= '0;
         rfWriteEnable_o <= 1'b0;
         rfWriteAddr_o   <= '0;
         memReqValid_o   <= 1'b0;
         memReqWrite_o   <= 1'b0;
         memReqAddr_o    <= '0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         err_o           <= 1'b0;
      end else begin
         done_o          <= 1'b0;
         err_o           <= 1'b0;
         rfReadEnable_o  <= 1'b0;
         rfWriteEnable_o <= 1'b0;
         case (state)
            IDLE: begin
               cmdReady_o <= 1'b1;
               if (cmd_accept) begin
                  cmdReady_o   <= 1'b0;
                  busy_o       <= 1'b1;
                  bankSelect_o <= cmdBank_i;
                  base_q       <= cmdBase_i;
                  idx          <= '0;
                  if (bank_bad) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                     err_o  <= 1'b1;
                  end else if (cmdFill_i == CMD_FILL) begin
                     state         <= FL_REQ;
                     memReqValid_o <= 1'b1;
                     memReqWrite_o <= 1'b0;
                     memReqAddr_o  <= cmdBase_i;
                  end else begin
                     state          <= SP_RD;
                     rfReadEnable_o <= 1'b1;
                     rfReadAddr_o   <= '0;
                  end
               end
            end
            SP_RD: begin
               state <= SP_CAP;
            end
            SP_CAP: begin
               data_q        <= rfReadData_i;
               memReqValid_o <= 1'b1;
               memReqWrite_o <= 1'b1;
               memReqAddr_o  <= word_addr(base_q, REG_W'(idx));
               state         <= SP_MEM;
            end
            SP_MEM: begin
               if (memReqReady_i) begin
                  memReqValid_o <= 1'b0;
                  memReqWrite_o <= 1'b0;
                  if (idx == LAST_IDX) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else begin
                     idx            <= idx_next;
                     state          <= SP_RD;
                     rfReadEnable_o <= 1'b1;
                     rfReadAddr_o   <= RF_ADDR_W'(idx_next);
                  end
               end
            end
            FL_REQ: begin
               if (memReqReady_i) begin
                  memReqValid_o <= 1'b0;
                  state         <= FL_RSP;
               end
            end
            FL_RSP: begin
               if (memRspValid_i) begin
                  data_q          <= memRspData_i;
                  rfWriteEnable_o <= 1'b1;
                  rfWriteAddr_o   <= RF_ADDR_W'(idx);
                  state           <= FL_WR;
               end
            end
            FL_WR: begin
               if (idx == LAST_IDX) begin
                  state  <= DONE;
                  done_o <= 1'b1;
               end else begin
                  idx           <= idx_next;
                  state         <= FL_REQ;
                  memReqValid_o <= 1'b1;
                  memReqWrite_o <= 1'b0;
                  memReqAddr_o  <= word_addr(base_q, REG_W'(idx_next));
               end
            end
            DONE: begin
               busy_o     <= 1'b0;
               cmdReady_o <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef REG_SPILL_CHECKSUM_EN
   logic cs_acc;

   // A word counts once: at the store handshake or in the RF write cycle.
   assign cs_acc = ((state == SP_MEM) && memReqReady_i) || (state == FL_WR);

   reg_spill_checksum u_checksum (
      .clk        (clock_i),
      .rst        (reset_i),
      .clear      (cmd_accept),
      .accumulate (cs_acc),
      .data       (data_q),
      .sum        (checksum_o)
   );
`else
   assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_reg_bank_spiller.sv
// Directed bench for reg_bank_spiller: RF and memory models, a monitor that
// logs traffic, and one linear initial block of checks.
module tb_reg_bank_spiller;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_fill;
   logic [5:0]  cmd_bank, bank_sel;
   logic [15:0] cmd_base;
   logic        rf_rd_en, rf_wr_en;
   logic [4:0]  rf_rd_addr, rf_wr_addr;
   logic [15:0] rf_rd_data = 16'h0;
   logic [15:0] rf_wr_data;
   logic        req_valid, mem_ready, req_write;
   logic [15:0] req_addr, req_data;
   logic        rsp_valid = 1'b0;
   logic [15:0] rsp_data = 16'h0;
   logic        busy, done, err;
   logic [15:0] checksum;
   logic [2:0]  state;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] rf_img [64][32];
   logic [31:0] exp_q[$];
   logic [31:0] st_q[$];
   logic [31:0] wr_q[$];

   // Stall control, written only by the stimulus block.
   logic        stall_on = 1'b0;
   logic [15:0] stall_addr = 16'h0;
   int          stall_limit = 0;
   int          rsp_lat = 3;

   // Monitor state, written only by the monitor.
   int cyc = 0, rd_cnt = 0, ld_cnt = 0, en_cnt = 0, done_cnt = 0, rsp_seen = 0;
   int overlap_cnt = 0, stall_cnt = 0, unstable_cnt = 0, acc_cyc = 0, done_cyc = 0;
   logic        last_err = 1'b0;
   logic [15:0] last_cs = 16'h0;
   logic        prev_stall = 1'b0;
   logic [32:0] prev_req = 33'h0;

   int          rsp_cnt = 0;
   logic [15:0] rsp_pend = 16'h0;

`ifdef REG_SPILL_CHECKSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif

   always #5 clock = ~clock;

   assign mem_ready = !(stall_on && req_valid && req_write && (req_addr == stall_addr) &&
                        (stall_cnt < stall_limit));

   reg_bank_spiller dut (
      .clock_i         (clock),
      .reset_i         (reset),
      .cmdValid_i      (cmd_valid),
      .cmdReady_o      (cmd_ready),
      .cmdFill_i       (cmd_fill),
      .cmdBank_i       (cmd_bank),
      .cmdBase_i       (cmd_base),
      .bankSelect_o    (bank_sel),
      .rfReadEnable_o  (rf_rd_en),
      .rfReadAddr_o    (rf_rd_addr),
      .rfReadData_i    (rf_rd_data),
      .rfWriteEnable_o (rf_wr_en),
      .rfWriteAddr_o   (rf_wr_addr),
      .rfWriteData_o   (rf_wr_data),
      .memReqValid_o   (req_valid),
      .memReqReady_i   (mem_ready),
      .memReqWrite_o   (req_write),
      .memReqAddr_o    (req_addr),
      .memReqData_o    (req_data),
      .memRspValid_i   (rsp_valid),
      .memRspData_i    (rsp_data),
      .busy_o          (busy),
      .done_o          (done),
      .err_o           (err),
      .checksum_o      (checksum),
      .state_o         (state)
   );

   // Register file read port: one-cycle registered read.
   always @(posedge clock) begin
      if (rf_rd_en) rf_rd_data <= rf_img[bank_sel][rf_rd_addr];
   end

   // Memory load responses: rsp_lat cycles after the load handshake,
   // data = 0x5A00 + (address - 0x0200).
   always @(posedge clock) begin
      rsp_valid <= 1'b0;
      if (rsp_cnt == 1) begin
         rsp_valid <= 1'b1;
         rsp_data  <= rsp_pend;
      end
      if (rsp_cnt != 0) rsp_cnt <= rsp_cnt - 1;
      if (req_valid && mem_ready && !req_write) begin
         rsp_pend <= req_addr - 16'h0200 + 16'h5A00;
         rsp_cnt  <= rsp_lat - 1;
      end
   end

   // Traffic monitor.
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (cmd_valid && cmd_ready) acc_cyc <= cyc;
      if (done) begin
         done_cyc <= cyc;
         done_cnt <= done_cnt + 1;
         last_err <= err;
         last_cs  <= checksum;
      end
      if (rf_rd_en) rd_cnt <= rd_cnt + 1;
      if (rf_wr_en) wr_q.push_back({11'h0, rf_wr_addr, rf_wr_data});
      if (rf_rd_en && rf_wr_en) overlap_cnt <= overlap_cnt + 1;
      if (rf_rd_en || rf_wr_en || req_valid) en_cnt <= en_cnt + 1;
      if (req_valid && mem_ready && req_write) st_q.push_back({req_addr, req_data});
      if (req_valid && mem_ready && !req_write) ld_cnt <= ld_cnt + 1;
      if (rsp_valid) rsp_seen <= rsp_seen + 1;
      if (req_valid && !mem_ready) stall_cnt <= stall_cnt + 1;
      if (req_valid && prev_stall && ({req_write, req_addr, req_data} != prev_req))
         unstable_cnt <= unstable_cnt + 1;
      prev_stall <= req_valid && !mem_ready;
      prev_req   <= {req_write, req_addr, req_data};
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({24'h0, cmd_ready, busy, done, err, rf_rd_en, rf_wr_en, req_valid, req_write}, 0,
          {tag, "_ctl"});
      chk({16'h0, bank_sel, rf_rd_addr, rf_wr_addr}, 0, {tag, "_addr"});
      chk({16'h0, rf_wr_data}, 0, {tag, "_wdata"});
      chk({req_addr, req_data}, 0, {tag, "_req"});
      chk({16'h0, checksum}, 0, {tag, "_cs"});
   endtask

   task automatic issue(input logic fill, input logic [5:0] bank, input logic [15:0] base);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      cmd_valid = 1'b1;
      cmd_fill  = fill;
      cmd_bank  = bank;
      cmd_base  = base;
      step();
      // Scramble command inputs after acceptance; the engine must not care.
      cmd_valid = 1'b0;
      cmd_fill  = ~fill;
      cmd_bank  = 6'd0;
      cmd_base  = 16'h0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < budget) begin
         step();
         n++;
      end
      chk(done_cnt - d0, 1, tag);
   endtask

   // which: 0 = memory stores, 1 = RF writes. Entries {addr, data}.
   task automatic check_seq(input int which, input int first, input logic [15:0] a0,
                            input logic [15:0] d0, input string tag);
      int sz;
      logic [31:0] obs;
      logic [31:0] exp;
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back({a0 + 16'(i), d0 + 16'(i)});
      sz = (which == 0) ? st_q.size() : wr_q.size();
      chk(sz - first, 16, {tag, "_count"});
      for (int i = 0; i < 16 && first + i < sz; i++) begin
         obs = (which == 0) ? st_q[first + i] : wr_q[first + i];
         exp = exp_q.pop_front();
         chk(obs, exp, $sformatf("%s_%0d", tag, i));
      end
   endtask

   function automatic logic [15:0] cs_model(input logic [15:0] d0);
      logic [15:0] x = 16'h0;
      for (int i = 0; i < 16; i++) x = x ^ (d0 + 16'(i));
      return CS_EN ? x : 16'h0;
   endfunction

   initial begin
      int s0, w0, r0, l0, e0, st0, u0, d0, n;
      cmd_valid = 1'b0;
      cmd_fill  = 1'b0;
      cmd_bank  = 6'd0;
      cmd_base  = 16'h0;
      for (int b = 0; b < 64; b++)
         for (int i = 0; i < 32; i++) rf_img[b][i] = 16'h1100 + 16'(i);
      for (int i = 0; i < 32; i++) rf_img[1][i] = 16'hA000 + 16'(i);

      // Reset
      #1 reset = 1'b1;
      step();
      check_all_zero("reset");
      chk({29'h0, state}, 0, "reset_state");
      reset = 1'b0;
      step();
      chk({31'h0, cmd_ready}, 1, "ready_after_reset");

      // Spill bank 1 to 0x0100
      s0 = st_q.size(); r0 = rd_cnt; l0 = ld_cnt;
      issue(1'b0, 6'd1, 16'h0100);
      chk({31'h0, cmd_ready}, 0, "spill_ready_low");
      chk({31'h0, busy}, 1, "spill_busy");
      chk({26'h0, rf_rd_en, rf_rd_addr}, {26'h0, 1'b1, 5'd0}, "spill_first_read");
      wait_done(200, "spill_done");
      chk(done_cyc - acc_cyc, 49, "spill_latency");
      chk({31'h0, last_err}, 0, "spill_err");
      chk({16'h0, last_cs}, {16'h0, cs_model(16'hA000)}, "spill_checksum");
      chk({31'h0, cmd_ready}, 1, "ready_after_done");
      chk({31'h0, busy}, 0, "idle_not_busy");
      chk(rd_cnt - r0, 16, "spill_reads");
      chk(ld_cnt - l0, 0, "spill_loads");
      check_seq(0, s0, 16'h0100, 16'hA000, "spill_st");

      // Fill bank 0 from 0x0200, response latency 3
      w0 = wr_q.size(); r0 = rd_cnt; l0 = ld_cnt; s0 = st_q.size();
      rsp_lat = 3;
      issue(1'b1, 6'd0, 16'h0200);
      chk({15'h0, req_valid, req_addr}, {15'h0, 1'b1, 16'h0200}, "fill_first_req");
      chk({31'h0, req_write}, 0, "fill_is_load");
      wait_done(400, "fill_done");
      chk(done_cyc - acc_cyc, 81, "fill_latency");
      chk({31'h0, last_err}, 0, "fill_err");
      chk({16'h0, last_cs}, {16'h0, cs_model(16'h5A00)}, "fill_checksum");
      chk(rd_cnt - r0, 0, "fill_reads");
      chk(ld_cnt - l0, 16, "fill_loads");
      chk(st_q.size() - s0, 0, "fill_stores");
      check_seq(1, w0, 16'h0000, 16'h5A00, "fill_wr");

      // Spill with a 5-cycle stall on index 3
      s0 = st_q.size(); st0 = stall_cnt; u0 = unstable_cnt;
      stall_on = 1'b1;
      stall_addr = 16'h0103;
      stall_limit = stall_cnt + 5;
      issue(1'b0, 6'd1, 16'h0100);
      wait_done(200, "stall_done");
      stall_on = 1'b0;
      chk(done_cyc - acc_cyc, 54, "stall_latency");
      chk(stall_cnt - st0, 5, "stall_cycles");
      chk(unstable_cnt - u0, 0, "stall_stable");
      check_seq(0, s0, 16'h0100, 16'hA000, "stall_st");

      // Out-of-range banks
      e0 = en_cnt;
      issue(1'b0, 6'd2, 16'h0400);
      wait_done(10, "err2_done");
      chk(done_cyc - acc_cyc, 1, "err2_latency");
      chk({31'h0, last_err}, 1, "err2_flag");
      issue(1'b1, 6'd63, 16'h0500);
      wait_done(10, "err63_done");
      chk({31'h0, last_err}, 1, "err63_flag");
      chk(en_cnt - e0, 0, "err_no_traffic");

      // Address wrap
      s0 = st_q.size();
      issue(1'b0, 6'd1, 16'hFFF8);
      wait_done(200, "wrap_done");
      check_seq(0, s0, 16'hFFF8, 16'hA000, "wrap_st");

      // Reset during FL_RSP of index 5
      w0 = wr_q.size(); d0 = done_cnt; r0 = rsp_seen;
      rsp_lat = 3;
      issue(1'b1, 6'd1, 16'h0300);
      n = 0;
      while (!(state == 3'd5 && wr_q.size() - w0 == 5) && n < 300) begin
         step();
         n++;
      end
      chk({29'h0, state}, 5, "reach_fl_rsp_idx5");
      #1 reset = 1'b1;
      #1 check_all_zero("async_reset");
      step();
      reset = 1'b0;
      step();
      chk({31'h0, cmd_ready}, 1, "ready_after_abort");
      repeat (5) step();
      chk(rsp_seen - r0, 6, "late_rsp_delivered");
      chk(wr_q.size() - w0, 5, "abort_writes");
      chk(done_cnt - d0, 0, "abort_no_done");
      chk({29'h0, state}, 0, "abort_idle");

      chk(overlap_cnt, 0, "rd_wr_overlap");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
